// File: rtl/oop_dac_ramp_ctrl.sv
// oop_dac_ramp_ctrl: slew-rate limited stepping of the OOP cathode DAC code toward a host target.
// Optional target clamping to [MIN_CODE, MAX_CODE] is enabled by `define OOP_DAC_LIMIT_EN.
module oop_dac_ramp_ctrl #(
   parameter logic [15:0] RESET_CODE    = 16'h0000,
   parameter int unsigned FRAME_TIMEOUT = 20000,
   parameter logic [15:0] MIN_CODE      = 16'h0000,
   parameter logic [15:0] MAX_CODE      = 16'hFFFF
) (
   input  logic        clk48mhz,
   input  logic        rstn,
   input  logic [15:0] host_target,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [15:0] ramp_step,
   input  logic [15:0] dwell_cycles,
   input  logic        abort,
   input  logic        frame_done,
   output logic [15:0] dac_value,
   output logic        dac_load,
   output logic        busy,
   output logic        at_target,
   output logic        fault,
   output logic        clamped
);
   localparam int TW = $clog2(FRAME_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, STEP, LOAD, WAIT_FRAME, DWELL} state_t;
   state_t state;
   logic [15:0] cur, tgt, nxt, dcnt, lim, diff;
   logic [16:0] up;
   logic [TW-1:0] tcnt;
   logic lim_chg;
   wire accept = host_valid && host_ready;
`ifdef OOP_DAC_LIMIT_EN
   assign lim = host_target < MIN_CODE ? MIN_CODE : host_target > MAX_CODE ? MAX_CODE : host_target;
   assign lim_chg = lim != host_target;
`else
   logic unused_lim;
   assign unused_lim = ^{MIN_CODE, MAX_CODE};
   assign lim = host_target;
   assign lim_chg = 1'b0;
`endif
   // compare-before-subtract keeps both directions wrap-free
   assign diff = tgt > cur ? tgt - cur : cur - tgt;
   assign up = {1'b0, cur} + {1'b0, ramp_step};
   always_ff @(posedge clk48mhz) begin
      if (!rstn) begin
         state      <= IDLE;
         cur        <= RESET_CODE;
         tgt        <= RESET_CODE;
         nxt        <= RESET_CODE;
         dac_value  <= RESET_CODE;
         dac_load   <= 1'b0;
         busy       <= 1'b0;
         at_target  <= 1'b1;
         fault      <= 1'b0;
         clamped    <= 1'b0;
         host_ready <= 1'b0;
         tcnt       <= '0;
         dcnt       <= '0;
      end else if (abort && state != IDLE) begin
         state     <= IDLE;
         tgt       <= cur;
         busy      <= 1'b0;
         at_target <= 1'b1;
         dac_load  <= 1'b0;
      end else begin
         dac_load <= 1'b0;
         case (state)
            IDLE: begin
               host_ready <= !accept;
               if (accept) begin
                  tgt       <= lim;
                  clamped   <= lim_chg;
                  fault     <= 1'b0;
                  busy      <= lim != cur;
                  at_target <= lim == cur;
                  state     <= lim == cur ? IDLE : STEP;
               end
            end
            STEP: begin
               nxt   <= (ramp_step == 16'd0 || diff <= ramp_step) ? tgt : tgt > cur ? up[15:0] : cur - ramp_step;
               state <= LOAD;
            end
            LOAD: begin
               cur       <= nxt;
               dac_value <= nxt;
               dac_load  <= 1'b1;
               tcnt      <= '0;
               state     <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (frame_done) begin
                  dcnt  <= '0;
                  state <= DWELL;
               end else if (tcnt == TW'(FRAME_TIMEOUT - 1)) begin
                  fault <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else
                  tcnt <= tcnt + 1'b1;
            end
            DWELL: begin
               if (dcnt >= dwell_cycles) begin
                  state     <= cur == tgt ? IDLE : STEP;
                  busy      <= cur != tgt;
                  at_target <= cur == tgt;
               end else
                  dcnt <= dcnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_oop_dac_ramp_ctrl.sv
// tb_oop_dac_ramp_ctrl: directed scoreboard bench for the OOP DAC ramp controller.
module tb_oop_dac_ramp_ctrl;
   localparam int FT = 60;
   logic clk48mhz = 1'b0, rstn = 1'b0, host_valid = 1'b0, abort = 1'b0, frame_done = 1'b0;
   logic [15:0] host_target = '0, ramp_step = '0, dwell_cycles = '0;
   logic host_ready, dac_load, busy, at_target, fault, clamped;
   logic [15:0] dac_value;
   logic fd_en = 1'b1;
   logic [15:0] q[$];
   logic [15:0] m_cur = 16'h0000;
   int vectors = 0, miscompares = 0;

   oop_dac_ramp_ctrl #(.RESET_CODE(16'h0000), .FRAME_TIMEOUT(FT), .MIN_CODE(16'h0000), .MAX_CODE(16'h4000)) dut (
      .clk48mhz(clk48mhz), .rstn(rstn), .host_target(host_target), .host_valid(host_valid),
      .host_ready(host_ready), .ramp_step(ramp_step), .dwell_cycles(dwell_cycles), .abort(abort),
      .frame_done(frame_done), .dac_value(dac_value), .dac_load(dac_load), .busy(busy),
      .at_target(at_target), .fault(fault), .clamped(clamped)
   );

   always #10 clk48mhz = ~clk48mhz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk48mhz);
   endtask

   function automatic logic [15:0] lim_t(input logic [15:0] t);
`ifdef OOP_DAC_LIMIT_EN
      return t > 16'h4000 ? 16'h4000 : t;
`else
      return t;
`endif
   endfunction

   task automatic req(input logic [15:0] t, input logic [15:0] st, input logic [15:0] dw);
      int n = 0;
      logic [15:0] m, e;
      while (!host_ready && n < 100) begin tick(1); n++; end
      check("host_ready", {31'd0, host_ready}, 32'd1);
      e = lim_t(t);
      m = m_cur;
      while (m != e) begin
         if (st == 16'd0 || (e > m ? e - m : m - e) <= st) m = e;
         else m = e > m ? m + st : m - st;
         q.push_back(m);
      end
      m_cur = e;
      host_target = t; ramp_step = st; dwell_cycles = dw; host_valid = 1'b1;
      tick(1);
      host_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      tick(1);
      while ((busy || !host_ready) && n < 2000) begin tick(1); n++; end
      check("idle", {30'd0, busy, host_ready}, 32'd1);
   endtask

   initial forever begin
      @(negedge clk48mhz);
      if (rstn && dac_load) begin
         vectors++;
         assert (q.size() != 0) else begin
            miscompares++;
            $error("FAIL load_extra observed %h expected no load", dac_value);
         end
         if (q.size() != 0) check("load_value", {16'd0, dac_value}, {16'd0, q.pop_front()});
      end
   end

   initial forever begin
      @(negedge clk48mhz);
      if (rstn && dac_load && fd_en) begin
         tick(9);
         frame_done = 1'b1;
         tick(1);
         frame_done = 1'b0;
      end
   end

   initial begin
      int n;
      tick(3);
      check("rst_dac", {16'd0, dac_value}, 32'h0);
      check("rst_flags", {25'd0, dac_load, busy, at_target, fault, clamped, host_ready, 1'b0}, {25'd0, 7'b0010000});
      rstn = 1'b1;
      tick(1);
      check("ready_after_rst", {31'd0, host_ready}, 32'd1);

      req(16'h0100, 16'h0040, 16'd4);
      tick(1);
      check("lat_step", {31'd0, dac_load}, 32'd0);
      tick(1);
      check("lat_load", {31'd0, dac_load}, 32'd1);
      wait_idle();
      check("t1_value", {16'd0, dac_value}, 32'h0100);
      check("t1_at_target", {31'd0, at_target}, 32'd1);
      check("t1_q", q.size(), 32'd0);

      req(16'hFFF0, 16'h0000, 16'd0); wait_idle();
      req(16'hFFFF, 16'h0020, 16'd1); wait_idle();
      check("t2_top", {16'd0, lim_t(16'hFFFF)}, {16'd0, dac_value});
      req(16'h0010, 16'h0000, 16'd0); wait_idle();
      req(16'h0000, 16'h0020, 16'd1); wait_idle();
      check("t2_bottom", {16'd0, dac_value}, 32'h0000);

      req(16'h8000, 16'h0000, 16'd0); wait_idle();
      check("t3_jump", {16'd0, dac_value}, {16'd0, lim_t(16'h8000)});
      req(lim_t(16'h8000), 16'h0000, 16'd0);
      check("t3_eq_flags", {30'd0, at_target, busy}, 32'd2);
      tick(10);
      check("t3_q", q.size(), 32'd0);

      req(16'h0000, 16'h0000, 16'd0); wait_idle();
      req(16'h1000, 16'h0100, 16'd2);
      n = 0;
      while (!(dac_load && dac_value == 16'h0300) && n < 500) begin tick(1); n++; end
      check("t4_third_load", {16'd0, dac_value}, 32'h0300);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("t4_abort", {13'd0, busy, at_target, dac_load, dac_value}, {13'd0, 3'b010, 16'h0300});
      q.delete();
      m_cur = 16'h0300;
      tick(15);
      check("t4_hold", {16'd0, dac_value}, 32'h0300);
      req(16'h0200, 16'h0000, 16'd0); wait_idle();
      check("t4_new", {16'd0, dac_value}, 32'h0200);

      fd_en = 1'b0;
      req(16'h0400, 16'h0000, 16'd0);
      n = 0;
      while (!dac_load && n < 20) begin tick(1); n++; end
      n = 0;
      while (!fault && n < 4 * FT) begin tick(1); n++; end
      check("t5_timeout_cycles", n, FT);
      check("t5_fault", {14'd0, fault, busy, dac_value}, {14'd0, 2'b10, 16'h0400});
      fd_en = 1'b1;
      req(16'h0500, 16'h0000, 16'd0);
      check("t5_fault_clr", {31'd0, fault}, 32'd0);
      wait_idle();
      check("t5_value", {16'd0, dac_value}, 32'h0500);

      req(16'h9000, 16'h0000, 16'd0); wait_idle();
`ifdef OOP_DAC_LIMIT_EN
      check("t6_clamp", {15'd0, clamped, dac_value}, {15'd0, 1'b1, 16'h4000});
`else
      check("t6_clamp", {15'd0, clamped, dac_value}, {15'd0, 1'b0, 16'h9000});
`endif

      req(16'h1000, 16'h0010, 16'd0);
      tick(8);
      rstn = 1'b0;
      tick(1);
      check("rst_mid", {14'd0, busy, dac_load, dac_value}, 32'h0);
      rstn = 1'b1;
      q.delete();
      m_cur = 16'h0000;
      tick(2);
      check("rst_mid_ready", {30'd0, host_ready, at_target}, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
